// File: rtl/mv_pkg.sv
// Shared constants, index helpers and element types for the matrix-vector engine.
package mv_pkg;

    localparam int DEF_M     = 16;
    localparam int DEF_N     = 16;
    localparam int DEF_DW    = 32;
    localparam int DEF_ACC_W = 2 * DEF_DW + 8;

    // Element and accumulator types at the default widths.
    typedef logic signed [DEF_DW-1:0]    elem_t;
    typedef logic signed [DEF_ACC_W-1:0] acc_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int p = 1; p < v; p = p * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Number of registered adder levels for an n-wide tile.
    function automatic int tree_depth(input int n);
        return clog2(n);
    endfunction

    // Cycles from an accepted last beat to out_valid: products, tree, accumulate.
    function automatic int lat_of(input int n);
        return tree_depth(n) + 2;
    endfunction

    // LSB of matrix element (r,c) in the row-major tile packing.
    function automatic int mat_lsb(input int r, input int c, input int n, input int dw);
        return (r * n + c) * dw;
    endfunction

    // LSB of vector element c.
    function automatic int vec_lsb(input int c, input int dw);
        return c * dw;
    endfunction

    // LSB of result row r.
    function automatic int out_lsb(input int r, input int acc_w);
        return r * acc_w;
    endfunction

    // First node index of adder level k (k = 1..L) in the flattened tree
    // storage; level sizes are n/2, n/4, ..., 1.
    function automatic int node_off(input int n, input int k);
        return n - (n >> (k - 1));
    endfunction

endpackage

// File: rtl/matvec_stream_engine_if.sv
// Tile input stream and result output stream of the matrix-vector engine.
interface matvec_stream_engine_if
    import mv_pkg::*;
#(
    parameter int M     = DEF_M,
    parameter int N     = DEF_N,
    parameter int DW    = DEF_DW,
    parameter int ACC_W = DEF_ACC_W
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DW*N*M-1:0]     in_mat;
    logic [DW*N-1:0]       in_vec;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_W*M-1:0]    out_vec;
    logic [15:0]           out_kcount;

    // Producer of tiles / consumer of results.
    modport master (
        output in_valid, in_mat, in_vec, in_last, out_ready,
        input  in_ready, out_valid, out_vec, out_kcount
    );

    // The engine.
    modport slave (
        input  in_valid, in_mat, in_vec, in_last, out_ready,
        output in_ready, out_valid, out_vec, out_kcount
    );
endinterface

// File: rtl/mv_dot_lane.sv
// One result row: N registered products feeding a registered pairwise adder
// tree, with valid/last carried alongside. Everything holds when en_i is low.
module mv_dot_lane
    import mv_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int DW    = DEF_DW,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              valid_i,
    input  logic              last_i,
    input  logic [N*DW-1:0]   row_i,
    input  logic [N*DW-1:0]   vec_i,
    output logic              valid_o,
    output logic              last_o,
    output logic [ACC_W-1:0]  sum_o
);
    localparam int L     = tree_depth(N);
    localparam int PW    = 2 * DW;
    localparam int NODES = N - 1;

    logic [PW-1:0]          prod_d [N];
    logic [PW-1:0]          prod_q [N];
    logic [NODES*ACC_W-1:0] tree_d;
    logic [NODES*ACC_W-1:0] tree_q;
    logic [L:0]             vld_d;
    logic [L:0]             vld_q;
    logic [L:0]             last_d;
    logic [L:0]             last_q;

    // Sign-extend a DW-wide operand to product width.
    function automatic logic [PW-1:0] sext_op(input logic [DW-1:0] v);
        return {{DW{v[DW-1]}}, v};
    endfunction

    // Sign-extend a product to accumulator width before the tree.
    function automatic logic [ACC_W-1:0] sext_prod(input logic [PW-1:0] p);
        return {{(ACC_W-PW){p[PW-1]}}, p};
    endfunction

    // Product stage: low PW bits of the sign-extended multiply are the exact signed product.
    always_comb begin
        for (int c = 0; c < N; c++) begin
            if (en_i) begin
                prod_d[c] = sext_op(row_i[vec_lsb(c, DW) +: DW]) * sext_op(vec_i[vec_lsb(c, DW) +: DW]);
            end else begin
                prod_d[c] = prod_q[c];
            end
        end
    end

    // Adder tree: level 1 sums product pairs, each later level sums pairs of the previous one.
    always_comb begin
        tree_d = tree_q;
        if (en_i) begin
            for (int k = 1; k <= L; k++) begin
                for (int i = 0; i < (N >> k); i++) begin
                    if (k == 1) begin
                        tree_d[i*ACC_W +: ACC_W] = sext_prod(prod_q[2*i]) + sext_prod(prod_q[2*i+1]);
                    end else begin
                        tree_d[(node_off(N, k) + i)*ACC_W +: ACC_W] =
                            tree_q[(node_off(N, k-1) + 2*i)*ACC_W +: ACC_W] +
                            tree_q[(node_off(N, k-1) + 2*i + 1)*ACC_W +: ACC_W];
                    end
                end
            end
        end else begin
            tree_d = tree_q;
        end
    end

    // Valid/last sideband shift register, one bit per stage.
    always_comb begin
        if (en_i) begin
            vld_d  = {vld_q[L-1:0], valid_i};
            last_d = {last_q[L-1:0], last_i};
        end else begin
            vld_d  = vld_q;
            last_d = last_q;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N; c++) begin
                prod_q[c] <= '0;
            end
            tree_q <= '0;
            vld_q  <= '0;
            last_q <= '0;
        end else begin
            for (int c = 0; c < N; c++) begin
                prod_q[c] <= prod_d[c];
            end
            tree_q <= tree_d;
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end

    assign valid_o = vld_q[L];
    assign last_o  = last_q[L];
    assign sum_o   = tree_q[node_off(N, L)*ACC_W +: ACC_W];

endmodule

// File: rtl/matvec_stream_engine.sv
// Streaming y = A*x engine: M dot-product lanes over N-column tiles, partial
// sums accumulated across tiles until a last beat, result held until consumed.
module matvec_stream_engine
    import mv_pkg::*;
#(
    parameter int M     = DEF_M,
    parameter int N     = DEF_N,
    parameter int DW    = DEF_DW,
    parameter int ACC_W = DEF_ACC_W
) (
    input logic                    clk,
    input logic                    rst_n,
    matvec_stream_engine_if.slave  bus
);
    logic                 adv_s;
    logic [M-1:0]         lane_valid_s;
    logic [M-1:0]         lane_last_s;
    logic [M*ACC_W-1:0]   lane_sum_s;
    logic                 beat_valid_s;
    logic                 beat_last_s;
    logic [M*ACC_W-1:0]   acc_nx_s;
    logic [15:0]          kcnt_nx_s;

    logic [M*ACC_W-1:0]   acc_d,        acc_q;
    logic [15:0]          kcnt_d,       kcnt_q;
    logic                 first_d,      first_q;
    logic                 out_valid_d,  out_valid_q;
    logic [M*ACC_W-1:0]   out_vec_d,    out_vec_q;
    logic [15:0]          out_kcount_d, out_kcount_q;

    // The whole pipeline advances unless a held result is waiting on the consumer.
    assign adv_s        = !(out_valid_q && !bus.out_ready);
    assign bus.in_ready = adv_s && rst_n;

    for (genvar r = 0; r < M; r++) begin : g_lane
        mv_dot_lane #(
            .N     (N),
            .DW    (DW),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (adv_s),
            .valid_i (bus.in_valid),
            .last_i  (bus.in_last),
            .row_i   (bus.in_mat[mat_lsb(r, 0, N, DW) +: N*DW]),
            .vec_i   (bus.in_vec),
            .valid_o (lane_valid_s[r]),
            .last_o  (lane_last_s[r]),
            .sum_o   (lane_sum_s[out_lsb(r, ACC_W) +: ACC_W])
        );
    end

    // All lanes run in lockstep, so their sidebands agree.
    assign beat_valid_s = &lane_valid_s;
    assign beat_last_s  = &lane_last_s;

    // Candidate accumulator and tile count if the beat at the tree output is taken.
    always_comb begin
        acc_nx_s = acc_q;
        for (int r = 0; r < M; r++) begin
            if (first_q) begin
                acc_nx_s[out_lsb(r, ACC_W) +: ACC_W] = lane_sum_s[out_lsb(r, ACC_W) +: ACC_W];
            end else begin
                acc_nx_s[out_lsb(r, ACC_W) +: ACC_W] = acc_q[out_lsb(r, ACC_W) +: ACC_W] +
                                                       lane_sum_s[out_lsb(r, ACC_W) +: ACC_W];
            end
        end
        if (first_q) begin
            kcnt_nx_s = 16'd1;
        end else if (kcnt_q == 16'hFFFF) begin
            kcnt_nx_s = kcnt_q;
        end else begin
            kcnt_nx_s = kcnt_q + 16'd1;
        end
    end

    // Accumulate stage and output register update.
    always_comb begin
        acc_d        = acc_q;
        kcnt_d       = kcnt_q;
        first_d      = first_q;
        out_valid_d  = out_valid_q;
        out_vec_d    = out_vec_q;
        out_kcount_d = out_kcount_q;

        if (adv_s && beat_valid_s) begin
            acc_d   = acc_nx_s;
            kcnt_d  = kcnt_nx_s;
            first_d = beat_last_s;
        end else begin
            acc_d   = acc_q;
            kcnt_d  = kcnt_q;
            first_d = first_q;
        end

        if (adv_s && beat_valid_s && beat_last_s) begin
            out_valid_d  = 1'b1;
            out_vec_d    = acc_nx_s;
            out_kcount_d = kcnt_nx_s;
        end else if (bus.out_ready) begin
            out_valid_d  = 1'b0;
        end else begin
            out_valid_d  = out_valid_q;
        end
    end

    // Accumulator, tile counter, first flag and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            kcnt_q       <= 16'd0;
            first_q      <= 1'b1;
            out_valid_q  <= 1'b0;
            out_vec_q    <= '0;
            out_kcount_q <= 16'd0;
        end else begin
            acc_q        <= acc_d;
            kcnt_q       <= kcnt_d;
            first_q      <= first_d;
            out_valid_q  <= out_valid_d;
            out_vec_q    <= out_vec_d;
            out_kcount_q <= out_kcount_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_vec    = out_vec_q;
    assign bus.out_kcount = out_kcount_q;

endmodule

// File: tb/tb_matvec_stream_engine.sv
// Directed bench for matvec_stream_engine at M=4, N=4, DW=8, ACC_W=24.
module tb_matvec_stream_engine;
    localparam int M     = 4;
    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int ACC_W = 24;
    localparam int LAT   = 4;
    localparam int MW    = DW * N * M;
    localparam int VW    = DW * N;
    localparam int OW    = ACC_W * M;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc       = 0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    logic [OW-1:0] res_vec [$];
    logic [15:0]   res_k   [$];
    int            res_cyc [$];

    matvec_stream_engine_if #(.M(M), .N(N), .DW(DW), .ACC_W(ACC_W)) bus ();

    matvec_stream_engine #(.M(M), .N(N), .DW(DW), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Result collector: a transfer is valid && ready, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            res_vec.push_back(bus.out_vec);
            res_k.push_back(bus.out_kcount);
            res_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [MW-1:0] mat_ident();
        logic [MW-1:0] m;
        m = '0;
        for (int r = 0; r < M; r++) m[(r*N+r)*DW +: DW] = 8'd1;
        return m;
    endfunction

    function automatic logic [MW-1:0] mat_fill(input logic [DW-1:0] v);
        logic [MW-1:0] m;
        for (int i = 0; i < N*M; i++) m[i*DW +: DW] = v;
        return m;
    endfunction

    function automatic logic [VW-1:0] vec4(input int a, input int b, input int c, input int d);
        logic [VW-1:0] v;
        v[0*DW +: DW] = DW'(a);
        v[1*DW +: DW] = DW'(b);
        v[2*DW +: DW] = DW'(c);
        v[3*DW +: DW] = DW'(d);
        return v;
    endfunction

    function automatic logic [OW-1:0] out4(input int a, input int b, input int c, input int d);
        logic [OW-1:0] o;
        o[0*ACC_W +: ACC_W] = ACC_W'(a);
        o[1*ACC_W +: ACC_W] = ACC_W'(b);
        o[2*ACC_W +: ACC_W] = ACC_W'(c);
        o[3*ACC_W +: ACC_W] = ACC_W'(d);
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic clear_results();
        res_vec.delete();
        res_k.delete();
        res_cyc.delete();
    endtask

    // Present one beat and hold it until accepted; acc_cyc is the accepting cycle.
    task automatic send(input logic [MW-1:0] a, input logic [VW-1:0] x, input logic last,
                        output int acc_cyc);
        int guard;
        bus.in_valid = 1'b1;
        bus.in_mat   = a;
        bus.in_vec   = x;
        bus.in_last  = last;
        #1;
        guard = 0;
        while (!bus.in_ready && guard < 64) begin
            step();
            #1;
            guard++;
        end
        if (guard >= 64) begin
            total_cnt++;
            $display("FAIL send_timeout: in_ready stayed %0b, required 1", bus.in_ready);
        end
        acc_cyc = cyc;
        step();
    endtask

    task automatic wait_results(input int n, input int budget);
        int g;
        g = 0;
        while (res_vec.size() < n && g < budget) begin
            step();
            g++;
        end
        if (res_vec.size() < n) begin
            total_cnt++;
            $display("FAIL wait_results: got %0d results, required %0d", res_vec.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_mat    = '0;
        bus.in_vec    = '0;
        idle();
        step();
        step();
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b, required 0", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready_low: got %0b, required 0", bus.in_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_vec !== {OW{1'b0}}) $display("FAIL reset_out_vec: got %h, required 0", bus.out_vec);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_kcount !== 16'd0) $display("FAIL reset_kcount: got %0d, required 0", bus.out_kcount);
        else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready_high: got %0b, required 1", bus.in_ready);
        else pass_cnt++;
        step();
    endtask

    task automatic test_identity();
        int ac;
        bus.out_ready = 1'b1;
        clear_results();
        send(mat_ident(), vec4(1, 2, 3, 4), 1'b1, ac);
        idle();
        wait_results(1, 20);
        repeat (4) step();
        total_cnt++;
        if (res_vec.size() != 1) $display("FAIL ident_count: got %0d, required 1", res_vec.size());
        else pass_cnt++;
        total_cnt++;
        if (res_cyc[0] - ac != LAT) $display("FAIL ident_latency: got %0d, required %0d", res_cyc[0] - ac, LAT);
        else pass_cnt++;
        total_cnt++;
        if (res_vec[0] !== out4(1, 2, 3, 4)) $display("FAIL ident_vec: got %h, required %h", res_vec[0], out4(1, 2, 3, 4));
        else pass_cnt++;
        total_cnt++;
        if (res_k[0] !== 16'd1) $display("FAIL ident_kcount: got %0d, required 1", res_k[0]);
        else pass_cnt++;
    endtask

    task automatic test_multi_tile();
        int ac;
        bus.out_ready = 1'b1;
        clear_results();
        send(mat_fill(8'd1), vec4(2, 2, 2, 2), 1'b0, ac);
        send(mat_fill(8'd1), vec4(2, 2, 2, 2), 1'b0, ac);
        send(mat_fill(8'd1), vec4(2, 2, 2, 2), 1'b1, ac);
        idle();
        wait_results(1, 20);
        repeat (4) step();
        total_cnt++;
        if (res_vec.size() != 1) $display("FAIL multi_count: got %0d, required 1", res_vec.size());
        else pass_cnt++;
        total_cnt++;
        if (res_cyc[0] - ac != LAT) $display("FAIL multi_latency: got %0d, required %0d", res_cyc[0] - ac, LAT);
        else pass_cnt++;
        total_cnt++;
        if (res_vec[0] !== out4(24, 24, 24, 24)) $display("FAIL multi_vec: got %h, required %h", res_vec[0], out4(24, 24, 24, 24));
        else pass_cnt++;
        total_cnt++;
        if (res_k[0] !== 16'd3) $display("FAIL multi_kcount: got %0d, required 3", res_k[0]);
        else pass_cnt++;
    endtask

    task automatic test_signed();
        int ac;
        bus.out_ready = 1'b1;
        clear_results();
        send(mat_fill(8'h80), vec4(-128, -128, -128, -128), 1'b1, ac);
        send(mat_fill(8'h7F), vec4(-128, -128, -128, -128), 1'b1, ac);
        idle();
        wait_results(2, 20);
        total_cnt++;
        if (res_vec[0] !== out4(65536, 65536, 65536, 65536)) $display("FAIL signed_neg_neg: got %h, required %h", res_vec[0], out4(65536, 65536, 65536, 65536));
        else pass_cnt++;
        total_cnt++;
        if (res_vec[1] !== out4(-65024, -65024, -65024, -65024)) $display("FAIL signed_pos_neg: got %h, required %h", res_vec[1], out4(-65024, -65024, -65024, -65024));
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int  k;
        logic accepted;
        clear_results();
        k = 1;
        for (int t = 0; t < 40; t++) begin
            bus.out_ready = !(t >= 5 && t < 12);
            if (k <= 6) begin
                bus.in_valid = 1'b1;
                bus.in_mat   = mat_ident();
                bus.in_vec   = vec4(k, k, k, k);
                bus.in_last  = 1'b1;
            end else begin
                idle();
            end
            #1;
            if (t >= 5 && t < 12) begin
                total_cnt++;
                if (bus.out_valid !== 1'b1) $display("FAIL bp_hold_valid t=%0d: got %0b, required 1", t, bus.out_valid);
                else pass_cnt++;
                total_cnt++;
                if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready t=%0d: got %0b, required 0", t, bus.in_ready);
                else pass_cnt++;
                total_cnt++;
                if (bus.out_vec !== out4(2, 2, 2, 2)) $display("FAIL bp_hold_vec t=%0d: got %h, required %h", t, bus.out_vec, out4(2, 2, 2, 2));
                else pass_cnt++;
            end
            accepted = bus.in_valid && bus.in_ready;
            step();
            if (accepted) k++;
        end
        idle();
        total_cnt++;
        if (res_vec.size() != 6) $display("FAIL bp_count: got %0d, required 6", res_vec.size());
        else pass_cnt++;
        for (int i = 0; i < 6 && i < res_vec.size(); i++) begin
            total_cnt++;
            if (res_vec[i] !== out4(i+1, i+1, i+1, i+1) || res_k[i] !== 16'd1)
                $display("FAIL bp_order[%0d]: got %h k=%0d, required %h k=1", i, res_vec[i], res_k[i], out4(i+1, i+1, i+1, i+1));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_midop();
        int ac;
        bus.out_ready = 1'b1;
        send(mat_fill(8'd1), vec4(1, 1, 1, 1), 1'b0, ac);
        send(mat_fill(8'd1), vec4(1, 1, 1, 1), 1'b0, ac);
        idle();
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_vec !== {OW{1'b0}} || bus.out_kcount !== 16'd0)
            $display("FAIL midrst_outputs: got valid=%0b ready=%0b vec=%h k=%0d, required all 0",
                     bus.out_valid, bus.in_ready, bus.out_vec, bus.out_kcount);
        else pass_cnt++;
        step();
        step();
        rst_n = 1'b1;
        clear_results();
        send(mat_fill(8'd1), vec4(1, 1, 1, 1), 1'b1, ac);
        idle();
        wait_results(1, 20);
        total_cnt++;
        if (res_vec[0] !== out4(4, 4, 4, 4)) $display("FAIL midrst_vec: got %h, required %h", res_vec[0], out4(4, 4, 4, 4));
        else pass_cnt++;
        total_cnt++;
        if (res_k[0] !== 16'd1) $display("FAIL midrst_kcount: got %0d, required 1", res_k[0]);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int ac;
        int c0;
        bus.out_ready = 1'b1;
        clear_results();
        c0 = 0;
        for (int k = 1; k <= 20; k++) begin
            send(mat_ident(), vec4(k, k, k, k), 1'b1, ac);
            if (k == 1) c0 = ac;
        end
        idle();
        wait_results(20, 60);
        for (int i = 0; i < 20 && i < res_vec.size(); i++) begin
            total_cnt++;
            if (res_cyc[i] != c0 + LAT + i || res_vec[i] !== out4(i+1, i+1, i+1, i+1))
                $display("FAIL stream[%0d]: got cyc=%0d vec=%h, required cyc=%0d vec=%h",
                         i, res_cyc[i], res_vec[i], c0 + LAT + i, out4(i+1, i+1, i+1, i+1));
            else pass_cnt++;
        end
    endtask

    task automatic test_random_gaps();
        int beats;
        int run_sum;
        int run_k;
        int v;
        int exp_sum [$];
        int exp_k   [$];
        beats   = 0;
        run_sum = 0;
        run_k   = 0;
        clear_results();
        for (int t = 0; t < 400 && beats < 40; t++) begin
            v             = $urandom_range(0, 30);
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.in_last   = (beats == 39) ? 1'b1 : ($urandom_range(0, 3) == 0);
            bus.in_mat    = mat_ident();
            bus.in_vec    = vec4(v, v, v, v);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.in_valid && bus.in_ready) begin
                run_sum += v;
                run_k++;
                beats++;
                if (bus.in_last) begin
                    exp_sum.push_back(run_sum);
                    exp_k.push_back(run_k);
                    run_sum = 0;
                    run_k   = 0;
                end
            end
            step();
        end
        idle();
        bus.out_ready = 1'b1;
        wait_results(exp_sum.size(), 100);
        repeat (4) step();
        total_cnt++;
        if (res_vec.size() != exp_sum.size()) $display("FAIL rand_count: got %0d, required %0d", res_vec.size(), exp_sum.size());
        else pass_cnt++;
        for (int i = 0; i < exp_sum.size() && i < res_vec.size(); i++) begin
            total_cnt++;
            if (res_vec[i] !== out4(exp_sum[i], exp_sum[i], exp_sum[i], exp_sum[i]) || res_k[i] !== 16'(exp_k[i]))
                $display("FAIL rand_result[%0d]: got %h k=%0d, required sum=%0d k=%0d",
                         i, res_vec[i], res_k[i], exp_sum[i], exp_k[i]);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_multi_tile();
        test_signed();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        test_random_gaps();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
